// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
//
// Sequential 16-bit right shifter. It accepts one operand and a 4-bit shift
// amount. It then applies the 1-, 2-, 4- and 8-bit right-shift stages over four
// clocks, reusing one stage datapath. The result is held until the consumer
// takes it.
//
// Optional feature, selected by the macro SHIFT_RIGHT_ARITH_EN:
//   defined   : arith=1 selects sign fill from the original data[15],
//               and arith=0 selects zero fill.
//   undefined : arith is accepted but ignored, and the fill is always zero.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   data         in  16   operand to shift
//   amt          in   4   right-shift amount, 0..15
//   arith        in   1   fill select (1 = sign fill, only with the macro)
//   in_valid     in   1   operand/amount valid
//   in_ready     out  1   block can accept an operand (IDLE)
//   q            out 16   working register / shifted result
//   out_valid    out  1   q holds a finished result (DONE)
//   out_ready    in   1   consumer takes q
//   dbg_state_o  out  2   current FSM state, for observation only
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   in_ready and out_valid are decoded only from registered state, so neither
//   depends combinationally on any input. The producer must hold data, amt and
//   arith stable while in_valid is high and in_ready is low. These inputs are
//   sampled only on the accept edge. q and out_valid stay stable until
//   out_ready is seen high at an edge.
// -----------------------------------------------------------------------------
module shift_right_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  amt,
  input  logic        arith,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state_o
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [15:0] work_q,  work_d;
  logic [3:0]  amt_q,   amt_d;
  logic        fill_q,  fill_d;

  logic        accept;
  logic        fill_sel;
  logic [15:0] stage_out;

  // ---------------------------------------------------------------------------
  // Fill-bit selection at the accept edge
  // ---------------------------------------------------------------------------
`ifdef SHIFT_RIGHT_ARITH_EN
  // Sign fill always replicates the operand's original MSB. Every stage uses
  // the latched copy, because the working register's MSB changes as it shifts.
  assign fill_sel = arith & data[15];
`else
  // arith stays on the port for drop-in compatibility but has no effect.
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_sel     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Shared stage datapath: stage cnt shifts right by 2**cnt
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_out = work_q;
    case (cnt_q)
      2'd0:    stage_out = {fill_q,         work_q[15:1]};
      2'd1:    stage_out = {{2{fill_q}},    work_q[15:2]};
      2'd2:    stage_out = {{4{fill_q}},    work_q[15:4]};
      2'd3:    stage_out = {{8{fill_q}},    work_q[15:8]};
      default: stage_out = work_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign accept = in_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    amt_d   = amt_q;
    fill_d  = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          work_d  = data;
          amt_d   = amt;
          fill_d  = fill_sel;
          cnt_d   = 2'd0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Amount bit cnt enables the stage of weight 2**cnt. amt=0 still runs
        // all four cycles, which keeps the latency fixed.
        if (amt_q[cnt_q]) begin
          work_d = stage_out;
        end
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DONE: begin
        // No new accept on the return edge. in_ready rises only after this.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= 16'h0000;
      amt_q   <= 4'd0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers, or direct decodes of the registered state
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign q           = work_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  amt;
  logic        arith;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  shift_right_seq dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .amt         (amt),
    .arith       (arith),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q           (q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dbg_state_o (dbg_state)
  );

`ifdef SHIFT_RIGHT_ARITH_EN
  localparam bit ARITH_EN = 1'b1;
`else
  localparam bit ARITH_EN = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: arithmetic on the signed or unsigned integer value
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] ref_shift(input logic [15:0] d,
                                            input logic [3:0] a,
                                            input logic ar);
    int v;
    int p;
    p = 1 << a;
    if (ARITH_EN && ar && d[15]) begin
      v = int'(d) - 65536;              // negative value
      // Floor division gives the arithmetic-shift result.
      v = (v - (p - 1)) / p;
      return 16'(v);
    end
    v = int'(d) / p;
    return 16'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one edge. Inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand at an idle DUT and check latency and the result.
  task automatic run_op(input string tag, input logic [15:0] d,
                        input logic [3:0] a, input logic ar);
    logic [15:0] e;
    e = ref_shift(d, a, ar);
    check({tag, "_idle_ready"}, 16'(in_ready), 16'd1);
    data = d; amt = a; arith = ar; in_valid = 1'b1;
    tick();                                     // E0: accept
    in_valid = 1'b0;
    data = 16'($urandom); amt = 4'($urandom); arith = 1'($urandom);
    for (int k = 1; k <= 3; k++) begin
      check({tag, "_busy_ready"}, 16'(in_ready), 16'd0);
      check({tag, "_early_valid"}, 16'(out_valid), 16'd0);
      tick();                                   // E1..E3
    end
    check({tag, "_pre_e4_valid"}, 16'(out_valid), 16'd0);
    tick();                                     // E4
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_q"}, q, e);
    check({tag, "_done_ready"}, 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    tick();                                     // return to IDLE
    out_ready = 1'b0;
    check({tag, "_ret_ready"}, 16'(in_ready), 16'd1);
    check({tag, "_ret_valid"}, 16'(out_valid), 16'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] hold_q;
    int          budget;
    int          got;

    rst = 1'b1; data = '0; amt = '0; arith = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_q", q, 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Directed cases from the test plan
    run_op("t8001_a1", 16'h8001, 4'd1, 1'b0);
    run_op("t8000_a15_ar", 16'h8000, 4'd15, 1'b1);
    check("a15_fixed", q, ARITH_EN ? 16'hFFFF : 16'h0001);
    run_op("tA5C3_a0", 16'hA5C3, 4'd0, 1'b0);
    check("a0_fixed", q, 16'hA5C3);
    run_op("tA5C3_a6", 16'hA5C3, 4'd6, 1'b0);
    check("a6_fixed", q, 16'h0297);
    run_op("t8F00_a4_ar", 16'h8F00, 4'd4, 1'b1);

    // Backpressure: hold out_ready low and pulse in_valid
    data = 16'h1234; amt = 4'd3; arith = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", 16'(out_valid), 16'd1);
    hold_q = q;
    check("bp_q", q, 16'h0246);
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      data = 16'($urandom); amt = 4'($urandom);
      tick();
      check("bp_hold_q", q, hold_q);
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ret_ready", 16'(in_ready), 16'd1);
    check("bp_ret_valid", 16'(out_valid), 16'd0);

    // Reset mid-SHIFT, after E2
    data = 16'hBEEF; amt = 4'd5; arith = 1'b1; in_valid = 1'b1;
    tick();                                     // E0
    in_valid = 1'b0;
    tick(); tick();                             // E1, E2
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", q, 16'h0000);
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_ready", 16'(in_ready), 16'd1);
    @(negedge clk); rst = 1'b0;
    tick();
    check("post_rst_valid", 16'(out_valid), 16'd0);
    run_op("t00F0_a4", 16'h00F0, 4'd4, 1'b0);
    check("a4_fixed", q, 16'h000F);

    // Streaming: in_valid always high with fresh data, random out_ready.
    // The scoreboard captures each operand seen at an accept edge.
    got = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'b1;
      data      = 16'($urandom);
      amt       = 4'($urandom_range(0, 15));
      arith     = 1'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready) exp_q.push_back(ref_shift(data, amt, arith));
      if (out_valid && out_ready) begin
        check("stream_q_nonempty", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0) check("stream_q", q, exp_q.pop_front());
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (out_valid) begin
        check("drain_q", q, exp_q.pop_front());
        got++;
      end
      tick();
      budget--;
    end
    check("drain_empty", 16'(exp_q.size()), 16'd0);
    check("stream_some_results", 16'(got > 10), 16'd1);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Sequential 16-bit right shifter, the right-direction counterpart to the combinational left-shift stages of the barrel shifter. It accepts one operand and a 4-bit shift amount over a valid/ready handshake. It then applies the 1-, 2-, 4- and 8-bit right-shift stages one per clock, and holds the result under a valid/ready output handshake. The block sits between the operand source and the result consumer wherever a right shift is needed at low area, trading latency for one shared stage datapath.

## Interface
- No parameters; datapath width fixed at 16 bits, amount width fixed at 4 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- data  input  16  operand to shift
- amt  input  4  right-shift amount, 0–15
- arith  input  1  fill select: 1 = sign fill (only with macro), 0 = zero fill
- in_valid  input  1  operand/amount valid
- in_ready  output  1  block can accept an operand
- q  output  16  shifted result
- out_valid  output  1  q holds a finished result
- out_ready  input  1  consumer takes q

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0. A 2-bit stage counter cnt runs 0..3.
  - DONE: in_ready=0, out_valid=1.
- Accept in IDLE:
  - Condition: in_valid && in_ready at a clock edge.
  - Registers data into the working register, latches amt, and latches arith.
  - Latches fill bit = arith ? data[15] : 0, subject to the Configuration section.
  - Sets cnt=0 and moves to SHIFT.
- SHIFT, each edge:
  - If amt[cnt]=1, the working register shifts right by 2^cnt. The vacated upper bits take the latched fill bit.
  - If amt[cnt]=0, the working register holds.
  - cnt increments. At cnt=3 the state moves to DONE instead.
- DONE:
  - q and out_valid are held stable until out_ready=1 at an edge, then the state moves to IDLE.
  - No new operand is accepted in DONE; the same-edge accept/return path is not supported.
- in_valid outside IDLE is ignored. data, amt and arith are not sampled outside the accept edge.
- amt=0 still traverses all four SHIFT cycles; q equals data.
- q is the working register, visible at all times. It is only meaningful while out_valid=1.
- Arithmetic rules:
  - Logical shift discards the low amt bits and zero-fills the top.
  - Sign fill replicates the original data[15] into the top amt bits.
  - amt=15 leaves only the original bit 15 in q[0].
- Reset, asynchronous, any state including mid-SHIFT or DONE:
  - State returns to IDLE and cnt=0.
  - q=16'h0000, out_valid=0, in_ready=1.
  - Any in-flight operation is discarded and no partial result is presented.

## Timing
- Accept at edge E0 leads to SHIFT stage edges E1..E4.
- out_valid rises after E4: latency is 4 cycles from the accept edge to out_valid.
- The earliest return to IDLE is the edge after out_valid rises with out_ready=1. in_ready rises on that edge.
- Maximum throughput is one operation per 6 cycles.
- All outputs are registers or decoded directly from registered state. There is no combinational path from any input to any output.
- Reset deassertion needs no special handling beyond the standard synchronous release of rst in the system.

## Configuration
- Macro SHIFT_RIGHT_ARITH_EN:
  - Defined: arith=1 selects sign fill from the original data[15]; arith=0 selects zero fill.
  - Undefined: the arith port remains present but is ignored, and the fill is always zero. The fill-select logic is not synthesized.

## Test plan
- data=16'h8001, amt=1, arith=0, accept at E0 -> out_valid high after E4, q=16'h4000. in_ready low from E0 until the return to IDLE.
- data=16'h8000, amt=15, arith=1 -> q=16'hFFFF with SHIFT_RIGHT_ARITH_EN defined, q=16'h0001 without it.
- data=16'hA5C3, amt=0 -> q=16'hA5C3 after the full 4-cycle latency. Then data=16'hA5C3, amt=6, arith=0 -> q=16'h0297.
- Backpressure: out_ready held low 3 cycles after out_valid -> q and out_valid stable throughout, and in_valid pulses ignored. out_ready=1 -> IDLE, with in_ready=1 the next cycle.
- Reset asserted mid-SHIFT (after E2) -> immediately q=16'h0000, out_valid=0, in_ready=1. After release a new operand (16'h00F0, amt=4) -> q=16'h000F at normal latency.
- in_valid asserted continuously with new data each cycle while busy -> only the operands present at IDLE accept edges are processed. The results match those operands in order.
